seven_segment_scan_ctrl: RTL and testbench

- Time-multiplexes one shared 7-segment decoder across the board's 4-digit common-anode display for the vending machine price/credit readout.
- Owns the refresh prescaler and the digit scan sequencer. Drives the decoder's 4-bit BCD input and the active-low digit anodes.
- Accepts new 4-digit BCD values through a valid/ready handshake. A new value takes effect only on a frame boundary, so the display never tears.

---
 rtl/seven_segment_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seven_segment_scan_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_ctrl.sv
// 4-digit common-anode scan controller: prescaled digit sequencer driving one
// shared BCD decoder, with a valid/ready update that commits on frame boundaries.
module seven_segment_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        upd_valid,
  input  logic [15:0] upd_bcd,
  output logic        upd_ready,
  output logic [3:0]  digit_code,
  output logic [3:0]  anode,
  output logic        frame_sync
);

  // state | meaning
  // IDLE  | no update held; upd_ready high, next valid is captured
  // PEND  | update held in pend_val, committed to active at next frame_end
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} upd_state_t;

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  upd_state_t    state, state_nxt;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   active, pend_val;
  logic          tick, frame_end;
  logic          capture, commit;
  logic [3:0]    nib;
  logic [3:1]    zero;
  logic          lead_zero, blank;

  assign tick      = (presc == PRESC_MAX);
  assign frame_end = tick && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (upd_valid) state_nxt = PEND;
      PEND:    if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A request arriving on frame_end while idle is only captured; it commits
  // one full frame later because commit requires PEND beforehand.
  always_comb begin
    upd_ready = (state == IDLE);
    capture   = upd_valid && (state == IDLE);
    commit    = frame_end && (state == PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= 16'h0000;
      active   <= 16'h0000;
    end else begin
      if (capture) pend_val <= upd_bcd;
      if (commit)  active   <= pend_val;
    end
  end

  always_comb begin
    case (idx)
      2'd1:    nib = active[7:4];
      2'd2:    nib = active[11:8];
      2'd3:    nib = active[15:12];
      default: nib = active[3:0];
    endcase
    zero[3] = (active[15:12] == 4'd0);
    zero[2] = (active[11:8]  == 4'd0);
    zero[1] = (active[7:4]   == 4'd0);
    case (idx)
      2'd3:    lead_zero = zero[3];
      2'd2:    lead_zero = zero[3] && zero[2];
      2'd1:    lead_zero = &zero;
      default: lead_zero = 1'b0;
    endcase
    blank = !enable || (nib > 4'd9) || (LZ_SUPPRESS && lead_zero);
  end

  // Outputs are refreshed every cycle so enable acts within one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_code <= 4'h0;
      anode      <= 4'b1111;
      frame_sync <= 1'b0;
    end else begin
      digit_code <= nib;
      anode      <= blank ? 4'b1111 : ~(4'b0001 << idx);
      frame_sync <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl: two instances (leading-zero blanking on/off)
// compared every cycle against a cycle-count based display model.
module tb_seven_segment_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_bcd = 16'h0000;
  logic        upd_ready, frame_sync, ready_nl, sync_nl;
  logic [3:0]  digit_code, anode, code_nl, anode_nl;

  int checks = 0;
  int errors = 0;

  seven_segment_scan_ctrl #(.REFRESH_DIV(DIV), .LZ_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .upd_valid(upd_valid),
    .upd_bcd(upd_bcd), .upd_ready(upd_ready), .digit_code(digit_code),
    .anode(anode), .frame_sync(frame_sync)
  );

  seven_segment_scan_ctrl #(.REFRESH_DIV(DIV), .LZ_SUPPRESS(1'b0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .upd_valid(upd_valid),
    .upd_bcd(upd_bcd), .upd_ready(ready_nl), .digit_code(code_nl),
    .anode(anode_nl), .frame_sync(sync_nl)
  );

  always #5 clk = ~clk;

  // Reference model: position in the frame follows from the number of clock
  // edges since reset; a digit is a leading zero when it and everything above it is zero.
  int          m_k;
  logic [15:0] m_active, m_pend_val;
  logic        m_has_pend;
  logic [3:0]  e_code, e_anode, e_anode_nolz;
  logic        e_sync, e_ready;

  assign e_ready = !m_has_pend;

  function automatic logic [3:0] f_anode(logic [15:0] v, int slot, logic en, bit lz);
    logic [3:0] n;
    bit lead;
    n = 4'((v >> (4 * slot)) & 16'h000F);
    lead = lz && (slot > 0) && ((v >> (4 * slot)) == 16'd0);
    if (!en || n > 4'd9 || lead) return 4'b1111;
    return ~(4'(1 << slot));
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int slot;
    bit fe;
    if (!rst_n) begin
      m_k <= 0; m_active <= 16'h0; m_pend_val <= 16'h0; m_has_pend <= 1'b0;
      e_code <= 4'h0; e_anode <= 4'hF; e_anode_nolz <= 4'hF; e_sync <= 1'b0;
    end else begin
      slot = (m_k / DIV) % 4;
      fe   = (m_k % FRAME) == FRAME - 1;
      e_code       <= 4'((m_active >> (4 * slot)) & 16'h000F);
      e_anode      <= f_anode(m_active, slot, enable, 1'b1);
      e_anode_nolz <= f_anode(m_active, slot, enable, 1'b0);
      e_sync       <= fe;
      if (fe && m_has_pend) begin
        m_active <= m_pend_val; m_has_pend <= 1'b0;
      end else if (upd_valid && !m_has_pend) begin
        m_pend_val <= upd_bcd; m_has_pend <= 1'b1;
      end
      m_k <= m_k + 1;
    end
  end

  task automatic test_reset();
    int last_sync;
    last_sync = -1;
    rst_n = 1'b0; enable = 1'b1; upd_valid = 1'b0; upd_bcd = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({anode, digit_code, frame_sync, upd_ready} !== {4'hF, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: anode=%b code=%h sync=%b ready=%b, expected 1111 0 0 1", anode, digit_code, frame_sync, upd_ready);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (anode !== 4'b1110 || digit_code !== 4'h0) begin
          errors++;
          $display("FAIL reset_first_digit: anode=%b code=%h, expected 1110 0", anode, digit_code);
        end
      end
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL reset_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
      checks++;
      if ({anode_nl, code_nl, sync_nl, ready_nl} !== {e_anode_nolz, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL reset_model_nolz k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode_nl, code_nl, sync_nl, ready_nl, e_anode_nolz, e_code, e_sync, e_ready);
      end
      if (frame_sync === 1'b1) begin
        if (last_sync >= 0) begin
          checks++;
          if (c - last_sync != FRAME) begin
            errors++;
            $display("FAIL reset_sync_period: got %0d cycles, expected %0d", c - last_sync, FRAME);
          end
        end
        last_sync = c;
      end
    end
  endtask

  task automatic test_update_mid_frame();
    logic [3:0] codes[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] ans[4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int after;
    after = -1;
    for (int i = 0; i < FRAME && (m_k % FRAME) != 6; i++) @(negedge clk);
    upd_valid = 1'b1; upd_bcd = 16'h1234;
    @(negedge clk);
    upd_valid = 1'b0;
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL upd_ready_drop: got %b, expected 0", upd_ready);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL update_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
      if (after >= 0 && after < FRAME) begin
        checks++;
        if (digit_code !== codes[after / DIV] || anode !== ans[after / DIV]) begin
          errors++;
          $display("FAIL update_scan slot %0d: code=%h anode=%b, expected %h %b", after / DIV, digit_code, anode, codes[after / DIV], ans[after / DIV]);
        end
      end
      if (after >= 0) after++;
      if (frame_sync === 1'b1 && after < 0) begin
        checks++;
        if (upd_ready !== 1'b1) begin
          errors++;
          $display("FAIL update_commit_ready: got %b, expected 1", upd_ready);
        end
        after = 0;
      end
    end
    checks++;
    if (after < 0) begin
      errors++;
      $display("FAIL update_commit_timeout: no frame_sync seen, expected one within a frame");
    end
  endtask

  task automatic test_leading_zero();
    int dark, dark_nl, after;
    dark = 0; dark_nl = 0; after = -1;
    for (int i = 0; i < 64 && !upd_ready; i++) @(negedge clk);
    upd_valid = 1'b1; upd_bcd = 16'h0050;
    @(negedge clk);
    upd_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL lz_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
      checks++;
      if ({anode_nl, code_nl, sync_nl, ready_nl} !== {e_anode_nolz, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL lz_model_nolz k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode_nl, code_nl, sync_nl, ready_nl, e_anode_nolz, e_code, e_sync, e_ready);
      end
      if (after >= 0 && after < FRAME) begin
        if (anode === 4'hF) dark++;
        if (anode_nl === 4'hF) dark_nl++;
      end
      if (after >= 0) after++;
      if (frame_sync === 1'b1 && after < 0) after = 0;
    end
    checks++;
    if (dark != 2 * DIV || dark_nl != 0) begin
      errors++;
      $display("FAIL lz_dark_slots: lz=%0d nolz=%0d dark cycles, expected %0d and 0", dark, dark_nl, 2 * DIV);
    end
  endtask

  task automatic test_invalid_bcd();
    int dark, mid, after;
    dark = 0; mid = 0; after = -1;
    for (int i = 0; i < 64 && !upd_ready; i++) @(negedge clk);
    upd_valid = 1'b1; upd_bcd = 16'h9A07;
    @(negedge clk);
    upd_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL invalid_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
      checks++;
      if ($countones(~anode) > 1 || $countones(~anode_nl) > 1) begin
        errors++;
        $display("FAIL invalid_one_hot: anode=%b nolz=%b, expected at most one low", anode, anode_nl);
      end
      if (after >= 0 && after < FRAME) begin
        if (anode === 4'hF) dark++;
        if (anode === 4'b1011) mid++;
      end
      if (after >= 0) after++;
      if (frame_sync === 1'b1 && after < 0) after = 0;
    end
    checks++;
    if (dark != DIV || mid != 0) begin
      errors++;
      $display("FAIL invalid_blank_slot: dark=%0d digit2_lit=%0d, expected %0d and 0", dark, mid, DIV);
    end
  endtask

  task automatic test_frame_end_update();
    for (int i = 0; i < 64 && !upd_ready; i++) @(negedge clk);
    for (int i = 0; i < FRAME && (m_k % FRAME) != FRAME - 1; i++) @(negedge clk);
    upd_valid = 1'b1; upd_bcd = 16'h0042;
    @(negedge clk);
    checks++;
    if (frame_sync !== 1'b1 || upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fe_capture: sync=%b ready=%b, expected 1 0", frame_sync, upd_ready);
    end
    upd_bcd = 16'h0777;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (c == 20) upd_valid = 1'b0;
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL fe_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
      if (c == FRAME) begin
        checks++;
        if (frame_sync !== 1'b1 || upd_ready !== 1'b1) begin
          errors++;
          $display("FAIL fe_commit: sync=%b ready=%b, expected 1 1", frame_sync, upd_ready);
        end
      end
      if (c == FRAME + 1) begin
        checks++;
        if (upd_ready !== 1'b0) begin
          errors++;
          $display("FAIL fe_second_capture: ready=%b, expected 0", upd_ready);
        end
      end
    end
  endtask

  task automatic test_enable();
    int syncs;
    syncs = 0;
    for (int i = 0; i < 64 && !upd_ready; i++) @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < FRAME + 4; c++) begin
      @(negedge clk);
      checks++;
      if (anode !== 4'hF || anode_nl !== 4'hF) begin
        errors++;
        $display("FAIL disabled_dark: anode=%b nolz=%b, expected 1111", anode, anode_nl);
      end
      if (frame_sync === 1'b1) syncs++;
    end
    checks++;
    if (syncs < 1) begin
      errors++;
      $display("FAIL disabled_sync: got %0d pulses, expected at least 1", syncs);
    end
    for (int i = 0; i < FRAME && (m_k % FRAME) != 9; i++) @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL reenable_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
    end
    for (int i = 0; i < 64 && !upd_ready; i++) @(negedge clk);
    for (int i = 0; i < FRAME && (m_k % FRAME) != 5; i++) @(negedge clk);
    upd_valid = 1'b1; upd_bcd = 16'h8888;
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({anode, anode_nl, upd_ready, frame_sync, digit_code} !== {4'hF, 4'hF, 1'b1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL midframe_reset: anode=%b nolz=%b ready=%b sync=%b code=%h, expected 1111 1111 1 0 0", anode, anode_nl, upd_ready, frame_sync, digit_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready} || digit_code === 4'h8) begin
        errors++;
        $display("FAIL after_reset_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if ({anode, digit_code, frame_sync, upd_ready} !== {e_anode, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL random_model k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode, digit_code, frame_sync, upd_ready, e_anode, e_code, e_sync, e_ready);
      end
      checks++;
      if ({anode_nl, code_nl, sync_nl, ready_nl} !== {e_anode_nolz, e_code, e_sync, e_ready}) begin
        errors++;
        $display("FAIL random_model_nolz k=%0d: got %b %h %b %b, expected %b %h %b %b", m_k, anode_nl, code_nl, sync_nl, ready_nl, e_anode_nolz, e_code, e_sync, e_ready);
      end
      checks++;
      if ($countones(~anode) > 1 || $countones(~anode_nl) > 1) begin
        errors++;
        $display("FAIL random_one_hot: anode=%b nolz=%b, expected at most one low", anode, anode_nl);
      end
      upd_valid = ($urandom_range(0, 3) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      for (int d = 0; d < 4; d++) begin
        upd_bcd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 11));
      end
    end
    upd_valid = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_update_mid_frame();
    test_leading_zero();
    test_invalid_bcd();
    test_frame_end_update();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
